// File: rtl/step_calc_pkg.sv
// step_calc_pkg
// Shared definitions for the step_calc responder: the sequencer state
// encoding and the operation-select constants carried on op_sel.
// No ports; imported by the interface and the responder module.
package step_calc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_INCR  = 3'd2,
    S_DONE  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/step_calc_resp_if.sv
// step_calc_resp_if
// Start/done command bus between an initiator and the step_calc responder.
//   start_sig : one-cycle command strobe (initiator -> responder)
//   op_sel    : 0 = add (a + b + 1), 1 = multiply (a * b)
//   a, b      : W-bit operands, sampled with start_sig
//   busy      : responder is working on a command
//   done_sig  : one-cycle completion pulse
//   result    : 2W-bit result, held until the next completion
// Modports: master = initiator side, slave = responder side.
interface step_calc_resp_if
  import step_calc_pkg::*;
#(
  parameter int W = 4
);

  logic           start_sig;
  logic           op_sel;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done_sig;
  logic [2*W-1:0] result;

  modport master (
    output start_sig, op_sel, a, b,
    input  busy, done_sig, result
  );

  modport slave (
    input  start_sig, op_sel, a, b,
    output busy, done_sig, result
  );

endinterface

// File: rtl/step_calc_resp.sv
// step_calc_resp
// Responder-side step sequencer. A start_sig pulse seen in S_IDLE latches
// the operands and operation; the result is built over registered steps
// (add: sum then increment; multiply: repeated addition of a, b times),
// then published on result with a one-cycle done_sig pulse.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : step_calc_resp_if slave modport (start_sig, op_sel, a, b in;
//           busy, done_sig, result out)
module step_calc_resp
  import step_calc_pkg::*;
#(
  parameter int W = 4
)(
  input  logic             clk,
  input  logic             rst_n,
  step_calc_resp_if.slave  bus
);

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic           op_r;
  logic [W-1:0]   cnt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] result_r;
  logic           done_r;

  // Step sequencing. Multiply stays in S_CALC until it has added a_r
  // exactly b_r times; b = 0 therefore goes straight to S_DONE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start_sig) state_next = S_CALC;
      S_CALC: begin
        if (op_r == OP_ADD)  state_next = S_INCR;
        else if (cnt == b_r) state_next = S_DONE;
      end
      S_INCR:  state_next = S_DONE;
      S_DONE:  state_next = S_CLEAR;
      S_CLEAR: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register plus the datapath registers it steps. Operands are
  // captured only on acceptance, so later changes on the bus are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= OP_ADD;
      cnt      <= '0;
      acc      <= '0;
      result_r <= '0;
      done_r   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (bus.start_sig) begin
            a_r  <= bus.a;
            b_r  <= bus.b;
            op_r <= bus.op_sel;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        S_CALC: begin
          if (op_r == OP_ADD) begin
            acc <= {{W{1'b0}}, a_r} + {{W{1'b0}}, b_r};
          end else if (cnt != b_r) begin
            acc <= acc + {{W{1'b0}}, a_r};
            cnt <= cnt + W'(1);
          end
        end
        S_INCR: acc <= acc + (2*W)'(1);
        S_DONE: begin
          result_r <= acc;
          done_r   <= 1'b1;
        end
        S_CLEAR: done_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done_sig = done_r;
  assign bus.result   = result_r;

endmodule

// File: tb/tb_step_calc_resp.sv
// tb_step_calc_resp
// Self-checking bench for step_calc_resp. Expected results and latencies
// come from the arithmetic definition of each command (add = a+b+1 after
// 3 steps, multiply = a*b after b+2 steps). Inputs change on the falling
// edge and outputs are sampled there as well.
module tb_step_calc_resp;
  import step_calc_pkg::*;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   last_result;

  step_calc_resp_if #(.W(W)) bus ();

  step_calc_resp #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    int           exp_result;
    int           exp_lat;
  } vec_t;

  vec_t vecs[8];

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issues one command so that it is sampled at the next rising edge (edge k).
  // Returns on the falling edge after edge k with junk on the operand lines.
  task automatic applyStimulus(input logic op, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    bus.start_sig = 1'b1;
    bus.op_sel    = op;
    bus.a         = av;
    bus.b         = bv;
    @(negedge clk);
    bus.start_sig = 1'b0;
    bus.op_sel    = 1'($urandom_range(0, 1));
    bus.a         = W'($urandom_range(0, 15));
    bus.b         = W'($urandom_range(0, 15));
  endtask

  // Runs one command and checks done/result/busy on every cycle until busy
  // drops. poke bit c re-asserts start_sig (add 9,9) after edge k+c.
  task automatic runAndCheck(input string tag, input logic op, input logic [W-1:0] av,
                             input logic [W-1:0] bv, input logic [31:0] poke);
    int ai;
    int bi;
    int exp_res;
    int lat;
    ai = int'(av);
    bi = int'(bv);
    exp_res = op ? ai * bi : ai + bi + 1;
    lat     = op ? bi + 2 : 3;
    applyStimulus(op, av, bv);
    checkOutput({tag, "_busy_rise"}, int'(bus.busy), 1);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c < lat) begin
        checkOutput({tag, "_done_early"}, int'(bus.done_sig), 0);
        checkOutput({tag, "_result_hold"}, int'(bus.result), last_result);
        checkOutput({tag, "_busy_mid"}, int'(bus.busy), 1);
      end else if (c == lat) begin
        checkOutput({tag, "_done"}, int'(bus.done_sig), 1);
        checkOutput({tag, "_result"}, int'(bus.result), exp_res);
        checkOutput({tag, "_busy_done"}, int'(bus.busy), 1);
      end else begin
        checkOutput({tag, "_done_fall"}, int'(bus.done_sig), 0);
        checkOutput({tag, "_busy_fall"}, int'(bus.busy), 0);
        checkOutput({tag, "_result_after"}, int'(bus.result), exp_res);
      end
      bus.start_sig = poke[c];
      if (poke[c]) begin
        bus.op_sel = OP_ADD;
        bus.a      = W'(9);
        bus.b      = W'(9);
      end else begin
        bus.op_sel = 1'($urandom_range(0, 1));
        bus.a      = W'($urandom_range(0, 15));
        bus.b      = W'($urandom_range(0, 15));
      end
    end
    bus.start_sig = 1'b0;
    last_result   = exp_res;
  endtask

  // Checks that the responder stays idle with no done pulse for n cycles.
  task automatic idleCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput({tag, "_no_done"}, int'(bus.done_sig), 0);
      checkOutput({tag, "_idle"}, int'(bus.busy), 0);
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    last_result   = 0;
    rst_n         = 1'b0;
    bus.start_sig = 1'b0;
    bus.op_sel    = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;

    vecs[0] = '{OP_ADD, 4'd1,  4'd2,  4,   3};
    vecs[1] = '{OP_MUL, 4'd3,  4'd5,  15,  7};
    vecs[2] = '{OP_MUL, 4'd7,  4'd0,  0,   2};
    vecs[3] = '{OP_ADD, 4'd15, 4'd15, 31,  3};
    vecs[4] = '{OP_MUL, 4'd15, 4'd15, 225, 17};
    vecs[5] = '{OP_ADD, 4'd0,  4'd0,  1,   3};
    vecs[6] = '{OP_MUL, 4'd1,  4'd15, 15,  17};
    vecs[7] = '{OP_MUL, 4'd15, 4'd1,  15,  3};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_done", int'(bus.done_sig), 0);
    checkOutput("reset_result", int'(bus.result), 0);
    rst_n = 1'b1;
    idleCycles("post_reset", 2);

    // Table-driven directed vectors; the hand-computed entries must agree
    // with the arithmetic rules used inside runAndCheck.
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("vec%0d_model_lat", i),
                  vecs[i].op ? int'(vecs[i].bv) + 2 : 3, vecs[i].exp_lat);
      checkOutput($sformatf("vec%0d_model_res", i),
                  vecs[i].op ? int'(vecs[i].av) * int'(vecs[i].bv)
                             : int'(vecs[i].av) + int'(vecs[i].bv) + 1,
                  vecs[i].exp_result);
      runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].av, vecs[i].bv, 32'h0);
    end

    // Start while busy: pokes at edge k+2 (S_CALC) and k+L+1 (S_CLEAR), L=6
    runAndCheck("busy_ignore", OP_MUL, 4'd2, 4'd4, (32'h1 << 1) | (32'h1 << 6));
    idleCycles("busy_ignore_after", 4);
    runAndCheck("add_9_9", OP_ADD, 4'd9, 4'd9, 32'h0);

    // Reset mid-operation: rst_n low sampled at edge k+4
    applyStimulus(OP_MUL, 4'd5, 4'd10);
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", int'(bus.busy), 0);
    checkOutput("midrst_done", int'(bus.done_sig), 0);
    checkOutput("midrst_result", int'(bus.result), 0);
    rst_n       = 1'b1;
    last_result = 0;
    idleCycles("midrst_after", 14);
    runAndCheck("midrst_add", OP_ADD, 4'd1, 4'd2, 32'h0);

    // Back-to-back: second command accepted at the first idle cycle
    runAndCheck("b2b_add", OP_ADD, 4'd1, 4'd2, 32'h0);
    runAndCheck("b2b_mul", OP_MUL, 4'd2, 4'd3, 32'h0);

    // Randomized commands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      runAndCheck($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                  W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/step_calc_resp.md
# step_calc_resp

Responder-side step sequencer: accepts a one-cycle `start_sig` command carrying two operands and an operation select. It computes the result over a fixed sequence of registered steps, then returns a one-cycle `done_sig` pulse with the result held stable. It is the worker end of the start/done step-sequencing scheme used by our sequencer blocks: an initiator pulses start, waits for done, and reads the result.

## Interface

Parameters:
- `W`, default 4: operand width; result width is 2·W.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `start_sig`, in, 1: command strobe, sampled only in S_IDLE.
- `op_sel`, in, 1: 0 = OP_ADD (a + b + 1); 1 = OP_MUL (a · b by repeated addition).
- `a`, in, W: operand A, sampled with `start_sig`.
- `b`, in, W: operand B, sampled with `start_sig`.
- `busy`, out, 1: high whenever the state is not S_IDLE.
- `done_sig`, out, 1: one-cycle completion pulse.
- `result`, out, 2W: last completed result; held until the next completion.

## Operation

- **Reset** (`rst_n` low at an edge): state goes to S_IDLE; `busy`, `done_sig`, `result` and all internal registers are cleared to 0. Reset mid-operation abandons the command; no `done_sig` is produced.
- **S_IDLE**: if `start_sig` is high, latch `a_r`, `b_r` and `op_r`, clear `acc` and `cnt`, and go to S_CALC. Otherwise stay.
- **S_CALC**:
  - OP_ADD: `acc <= a_r + b_r` (zero-extended to 2W), then go to S_INCR.
  - OP_MUL: if `cnt == b_r`, go to S_DONE. Otherwise `acc <= acc + a_r` and `cnt <= cnt + 1`, and stay in S_CALC.
- **S_INCR** (OP_ADD only): `acc <= acc + 1`, then go to S_DONE.
- **S_DONE**: `result <= acc`, `done_sig <= 1`, then go to S_CLEAR.
- **S_CLEAR**: `done_sig <= 0`, then go to S_IDLE.
- **Width**:
  - `cnt` is W bits.
  - Add maximum is 2·(2^W−1)+1, which fits in 2W bits for W ≥ 1.
  - Multiply maximum is (2^W−1)², which fits in 2W bits.
  - No overflow or wrap is possible; a saturation path is not required.
- **Command acceptance**: `start_sig` is ignored in every state except S_IDLE, including S_DONE and S_CLEAR. Nothing is queued.
- **Operand changes**: `a`, `b` and `op_sel` changing while busy have no effect.

## Timing

Let edge k be the edge at which `start_sig` is sampled in S_IDLE.

- `busy` rises after edge k and falls after edge k+L+1.
- OP_ADD: L = 3. `done_sig` is high between edges k+3 and k+4, and `result` is valid from edge k+3.
- OP_MUL: L = b_r + 2. For b = 0, `done_sig` is high after edge k+2.
- `result` changes only at the S_DONE edge.
- The earliest following command is accepted at edge k+L+2, i.e. the first S_IDLE cycle after `done_sig` falls.
- All outputs are registered or decoded directly from the state register; there is no combinational path from inputs to outputs.

## Structure

- Shared package `step_calc_pkg`:
  - state encoding: S_IDLE=0, S_CALC=1, S_INCR=2, S_DONE=3, S_CLEAR=4, in a 3-bit state type;
  - op constants OP_ADD=1'b0, OP_MUL=1'b1.
- A single module with one sequential always block carrying the step/state register. No sub-module is warranted.

## Test plan

- **Add**: add, a=1, b=2, start at edge k → `busy` from k+1; `result`=4 and `done_sig`=1 for exactly one cycle after edge k+3; `busy`=0 after k+4.
- **Multiply**: mul, a=3, b=5 → `result`=15 and `done_sig` after edge k+7. Also mul, a=7, b=0 → `result`=0 and `done_sig` after edge k+2.
- **Maximum operands**: add, a=15, b=15 → `result`=31 at k+3. Mul, a=15, b=15 → `result`=225 at k+17, with no wrap.
- **Start while busy**: start mul 2·4, then pulse `start_sig` with add 9,9 at k+2 and again during S_CLEAR → only `result`=8 is produced, with a single `done_sig`. A new add 9,9 issued after return to S_IDLE → 19.
- **Reset mid-operation**: start mul 5·10 and assert `rst_n`=0 at k+4 → after that edge `busy`=0, `done_sig`=0, `result`=0, and no done pulse follows. A subsequent add 1,2 completes normally with 4.
- **Back-to-back commands**: add 1,2 then mul 2,3 issued at the first S_IDLE cycle → `result` sequence 4, 6; `result` holds 4 until the second S_DONE edge.
